// File: rtl/seed_feeder.sv
// seed_feeder: initiator side of the keccak seed-input interface.
// The controller fills a DEPTH-entry buffer of 64-bit seed words while idle.
// An accepted go latches the job length and mode, pulses start_calc for one
// cycle, then streams words to keccak with in_valid/is_last, advancing on ack.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data buffer write port (honoured in IDLE only)
//   cfg_len, cfg_mode     job length (1..DEPTH) and keccak mode, sampled on go
//   go                    job start request (IDLE only)
//   ack                   keccak accepts the presented word
//   mode                  latched job mode
//   start_calc            one-cycle job-start pulse
//   in_valid, is_last     word valid / final word of job
//   seed_word             word presented to keccak
//   busy                  job in progress, buffer locked
//   finished              one-cycle pulse after the last word is accepted
//   err                   one-cycle pulse when go carries a bad cfg_len
module seed_feeder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [63:0]   wr_data,
  input  logic [AW:0]   cfg_len,
  input  logic [1:0]    cfg_mode,
  input  logic          go,
  input  logic          ack,
  output logic [1:0]    mode,
  output logic          start_calc,
  output logic          in_valid,
  output logic          is_last,
  output logic [63:0]   seed_word,
  output logic          busy,
  output logic          finished,
  output logic          err
);

  typedef enum logic [1:0] {StIdle, StStart, StSend, StDone} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [AW:0]     len_q, len_d;
  logic [1:0]      mode_q, mode_d;
  logic            err_q, err_d;
  logic [63:0]     buf_q [DEPTH];

  logic len_ok;
  logic addr_ok;
  logic last_word;

  assign len_ok    = (cfg_len != '0) && (cfg_len <= (AW+1)'(DEPTH));
  assign addr_ok   = ({1'b0, wr_addr} < (AW+1)'(DEPTH));
  assign last_word = ({1'b0, cnt_q} == (len_q - (AW+1)'(1)));

  // Buffer only changes in IDLE, so a running job always sees a frozen image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (state_q == StIdle && wr_en && addr_ok) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          if (len_ok) begin
            len_d   = cfg_len;
            mode_d  = cfg_mode;
            state_d = StStart;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        if (ack) begin
          if (last_word) state_d = StDone;
          else           cnt_d   = cnt_q + AW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode directly from reset-cleared state, so reset zeroes them at once.
  assign mode       = mode_q;
  assign start_calc = (state_q == StStart);
  assign in_valid   = (state_q == StSend);
  assign is_last    = (state_q == StSend) && last_word;
  assign seed_word  = (state_q == StSend) ? buf_q[cnt_q] : '0;
  assign busy       = (state_q != StIdle);
  assign finished   = (state_q == StDone);
  assign err        = err_q;

endmodule

// File: tb/tb_seed_feeder.sv
module tb_seed_feeder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic [AW:0]   cfg_len;
  logic [1:0]    cfg_mode;
  logic          go;
  logic          ack;
  logic [1:0]    mode;
  logic          start_calc;
  logic          in_valid;
  logic          is_last;
  logic [63:0]   seed_word;
  logic          busy;
  logic          finished;
  logic          err;

  int n_checks = 0;
  int n_fails  = 0;

  seed_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cfg_len    (cfg_len),
    .cfg_mode   (cfg_mode),
    .go         (go),
    .ack        (ack),
    .mode       (mode),
    .start_calc (start_calc),
    .in_valid   (in_valid),
    .is_last    (is_last),
    .seed_word  (seed_word),
    .busy       (busy),
    .finished   (finished),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [63:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mode"},       64'(mode),       64'h0);
    chk({tag, ".start_calc"}, 64'(start_calc), 64'h0);
    chk({tag, ".in_valid"},   64'(in_valid),   64'h0);
    chk({tag, ".is_last"},    64'(is_last),    64'h0);
    chk({tag, ".seed_word"},  seed_word,       64'h0);
    chk({tag, ".busy"},       64'(busy),       64'h0);
    chk({tag, ".finished"},   64'(finished),   64'h0);
    chk({tag, ".err"},        64'(err),        64'h0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    cfg_len = '0; cfg_mode = '0; go = 1'b0; ack = 1'b0;
    #2;
    chk_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();
    chk_all_zero("post_reset");

    // Basic 4-word job, ack tied high.
    for (int i = 0; i < 4; i++) write_word(AW'(i), 64'hA0 + 64'(i));
    cfg_len = 4'd4; cfg_mode = 2'd2; ack = 1'b1; go = 1'b1;
    tick();
    go = 1'b0;
    chk("a.start_calc", 64'(start_calc), 64'h1);
    chk("a.start_busy", 64'(busy), 64'h1);
    chk("a.start_valid", 64'(in_valid), 64'h0);
    chk("a.mode", 64'(mode), 64'h2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("a.valid", 64'(in_valid), 64'h1);
      chk("a.word", seed_word, 64'hA0 + 64'(i));
      chk("a.last", 64'(is_last), (i == 3) ? 64'h1 : 64'h0);
      chk("a.start_low", 64'(start_calc), 64'h0);
      chk("a.mode_hold", 64'(mode), 64'h2);
    end
    tick();
    chk("a.finished", 64'(finished), 64'h1);
    chk("a.done_valid", 64'(in_valid), 64'h0);
    chk("a.done_busy", 64'(busy), 64'h1);
    tick();
    chk("a.idle_busy", 64'(busy), 64'h0);
    chk("a.idle_fin", 64'(finished), 64'h0);
    chk("a.mode_after", 64'(mode), 64'h2);

    // Same job with ack low for 3 cycles on word1.
    cfg_mode = 2'd1; go = 1'b1;
    tick();
    go = 1'b0;
    chk("b.start_calc", 64'(start_calc), 64'h1);
    tick();
    chk("b.word0", seed_word, 64'hA0);
    tick();
    for (int k = 0; k < 4; k++) begin
      ack = (k == 3);
      chk("b.hold_word", seed_word, 64'hA1);
      chk("b.hold_valid", 64'(in_valid), 64'h1);
      chk("b.hold_last", 64'(is_last), 64'h0);
      tick();
    end
    chk("b.word2", seed_word, 64'hA2);
    tick();
    chk("b.word3", seed_word, 64'hA3);
    chk("b.last3", 64'(is_last), 64'h1);
    tick();
    chk("b.finished", 64'(finished), 64'h1);
    chk("b.mode", 64'(mode), 64'h1);
    tick();

    // Single-word job.
    write_word(AW'(0), 64'h1234);
    cfg_len = 4'd1; cfg_mode = 2'd3; ack = 1'b0; go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    chk("c.word", seed_word, 64'h1234);
    chk("c.valid", 64'(in_valid), 64'h1);
    chk("c.last", 64'(is_last), 64'h1);
    ack = 1'b1;
    tick();
    chk("c.finished", 64'(finished), 64'h1);
    chk("c.mode", 64'(mode), 64'h3);
    tick();

    // Bad lengths raise err only.
    cfg_len = 4'd0; go = 1'b1;
    tick();
    go = 1'b0;
    chk("d.err0", 64'(err), 64'h1);
    chk("d.start0", 64'(start_calc), 64'h0);
    chk("d.busy0", 64'(busy), 64'h0);
    tick();
    chk("d.err0_pulse", 64'(err), 64'h0);
    cfg_len = 4'd9; go = 1'b1;
    tick();
    go = 1'b0;
    chk("d.err9", 64'(err), 64'h1);
    chk("d.start9", 64'(start_calc), 64'h0);
    chk("d.busy9", 64'(busy), 64'h0);
    tick();
    chk("d.err9_pulse", 64'(err), 64'h0);
    chk("d.mode_kept", 64'(mode), 64'h3);

    // Writes and go while busy are ignored. Buffer: 1234, A1, A2, A3.
    cfg_len = 4'd4; cfg_mode = 2'd2; ack = 1'b1; go = 1'b1;
    tick();
    wr_en = 1'b1; wr_addr = '0; wr_data = 64'hFFFF; cfg_len = 4'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("e.word", seed_word, (i == 0) ? 64'h1234 : 64'hA0 + 64'(i));
      chk("e.last", 64'(is_last), (i == 3) ? 64'h1 : 64'h0);
      chk("e.no_start", 64'(start_calc), 64'h0);
      chk("e.no_err", 64'(err), 64'h0);
    end
    tick();
    chk("e.finished", 64'(finished), 64'h1);
    go = 1'b0; wr_en = 1'b0;
    tick();
    cfg_len = 4'd1; go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    chk("e.buf_kept", seed_word, 64'h1234);
    tick();
    tick();

    // Write and go on the same edge: new value is sent.
    wr_en = 1'b1; wr_addr = '0; wr_data = 64'h5555; cfg_len = 4'd1; go = 1'b1;
    tick();
    wr_en = 1'b0; go = 1'b0;
    tick();
    chk("f.same_edge", seed_word, 64'h5555);
    tick();
    tick();

    // Reset mid-SEND on word2 with ack low.
    cfg_len = 4'd4; cfg_mode = 2'd1; ack = 1'b1; go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    tick();
    ack = 1'b0;
    chk("g.word2", seed_word, 64'hA2);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("g.async");
    tick();
    rst = 1'b0;
    chk("g.busy_after", 64'(busy), 64'h0);
    ack = 1'b1; go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("g.cleared", seed_word, 64'h0);
      chk("g.valid", 64'(in_valid), 64'h1);
    end
    tick();
    chk("g.finished", 64'(finished), 64'h1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/seed_feeder.md
Name: seed_feeder

Overview:
- Initiator side of the keccak seed-input interface.
- Buffers up to DEPTH 64-bit seed words written by the controller.
- On `go`, emits a one-cycle `start_calc` pulse, then streams the words with `in_valid` and `is_last`, advancing on the keccak `ack`.
- Sits between the controller/SRAM side and the keccak core in the Hash datapath.

Parameters:
DEPTH, 8, number of 64-bit seed words the buffer holds (2..16)
AW, 3, address/length width; must satisfy 2**AW >= DEPTH

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
wr_en  input  1  write wr_data into buffer[wr_addr]
wr_addr  input  AW  buffer write index
wr_data  input  64  seed word to store
cfg_len  input  AW+1  number of words to send this job (1..DEPTH)
cfg_mode  input  2  keccak mode for this job
go  input  1  start job (sampled in IDLE only)
ack  input  1  keccak accepts the current word
mode  output  2  latched job mode to keccak
start_calc  output  1  one-cycle job-start pulse to keccak
in_valid  output  1  seed_word is valid
is_last  output  1  current word is the final word of the job
seed_word  output  64  seed word to keccak `in`
busy  output  1  job in progress, buffer locked
finished  output  1  one-cycle pulse after the last word is accepted
err  output  1  one-cycle pulse when go is rejected for a bad cfg_len

Behaviour:
- Reset is asynchronous; on assertion all of the following take effect immediately, including mid-job:
  - outputs: mode=0, start_calc=0, in_valid=0, is_last=0, seed_word=0, busy=0, finished=0, err=0;
  - buffer cleared to 0; word counter = 0; state = IDLE.
- IDLE:
  - busy=0.
  - wr_en writes buffer[wr_addr]. wr_addr >= DEPTH: write dropped.
  - go with cfg_len in 1..DEPTH: latch len and cfg_mode into `mode`, go to START.
  - go with cfg_len=0 or cfg_len>DEPTH: err=1 for one cycle, stay IDLE.
- START:
  - start_calc=1 for exactly this cycle, busy=1; then go to SEND with counter=0.
- SEND:
  - in_valid=1; seed_word=buffer[counter]; is_last=(counter==len-1).
  - Handshake: a transfer occurs on a rising edge where in_valid=1 and ack=1.
  - While ack=0: seed_word, is_last and in_valid are held stable.
  - On transfer of a non-last word: counter+1, next word presented in the following cycle. Peak rate is one word per cycle.
  - On transfer of the last word: go to DONE.
- DONE:
  - in_valid=0, is_last=0, finished=1 for one cycle, busy=1; then IDLE.
- ack while in_valid=0 (IDLE/START/DONE): ignored.
- busy=1 (START/SEND/DONE):
  - wr_en ignored; buffer contents frozen.
  - go ignored; err not raised.
- wr_en and go on the same IDLE edge: the write commits. Because the first word is read no earlier than 2 cycles later, the newly written value is sent.
- `mode` holds its latched value after the job ends, until the next accepted go.
- Latency:
  - go accepted at edge N; start_calc high in cycle N+1; word0 presented in cycle N+2.
  - With ack tied high, a job of L words completes with finished in cycle N+2+L.

Test Plan:
- Reset mid-SEND (word 2 of 4, ack=0) -> all outputs 0 asynchronously; after release, busy=0; buffer reads back 0 on the next job.
- Write words 0xA0..0xA3 to addr 0..3, cfg_len=4, cfg_mode=2, go, ack tied 1 -> start_calc pulse at N+1; seed_word A0,A1,A2,A3 at N+2..N+5; is_last only with A3; finished at N+6; mode=2 throughout.
- Same job, ack low for 3 cycles on word1 -> seed_word=A1, in_valid=1, is_last=0 held for 4 cycles; no skipped or duplicated word.
- cfg_len=1, word 0x1234 -> one word with is_last=1 together with in_valid on the same cycle; finished on the cycle after ack.
- go with cfg_len=0, and separately cfg_len=DEPTH+1 -> err pulses once each; no start_calc; busy stays 0.
- During busy: wr_en to addr 0 with 0xFFFF, plus a second go -> buffer unchanged; job word count unchanged; no second start_calc.
